// File: rtl/shift_reg_univ.sv
// Universal shift register: DEPTH stages of DATA_W-bit lanes. It supports parallel
// load, parallel readout, bidirectional shift, and a frame-done pulse after every
// DEPTH shifts. Parameters: DATA_W (lane width, >= 1) and DEPTH (number of stages,
// >= 2). Ports:
//   i_clk, i_rst (sync, active-high), i_en (shift), i_load (parallel load),
//   i_dir (0: toward MSB stage, 1: toward stage 0), i_ser_in, i_par_in,
//   o_ser_out (comb end stage), o_par_out, o_cnt, o_frame_done (registered).
// Optional macro SHIFT_REG_ROT_EN adds i_rot, which makes a shift rotate.
module shift_reg_univ #(
  parameter  int DATA_W = 1,
  parameter  int DEPTH  = 8,
  localparam int CNT_W  = $clog2(DEPTH)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic                    i_load,
  input  logic                    i_dir,
`ifdef SHIFT_REG_ROT_EN
  input  logic                    i_rot,
`endif
  input  logic [DATA_W-1:0]       i_ser_in,
  input  logic [DEPTH*DATA_W-1:0] i_par_in,
  output logic [DATA_W-1:0]       o_ser_out,
  output logic [DEPTH*DATA_W-1:0] o_par_out,
  output logic [CNT_W-1:0]        o_cnt,
  output logic                    o_frame_done
);

  logic [DEPTH-1:0][DATA_W-1:0] stage_q, stage_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         done_q, done_d;
  logic [DATA_W-1:0]            fb_up, fb_dn;

  // fb_up enters stage 0 on an up-shift, and fb_dn enters the MSB stage on a
  // down-shift. In rotate mode, each takes the stage that is leaving the opposite end.
`ifdef SHIFT_REG_ROT_EN
  assign fb_up = i_rot ? stage_q[DEPTH-1] : i_ser_in;
  assign fb_dn = i_rot ? stage_q[0] : i_ser_in;
`else
  assign fb_up = i_ser_in;
  assign fb_dn = i_ser_in;
`endif

  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (i_load) begin
      stage_d = i_par_in;
      cnt_d   = '0;
    end else if (i_en) begin
      if (!i_dir) begin
        stage_d = {stage_q[DEPTH-2:0], fb_up};
      end else begin
        stage_d = {fb_dn, stage_q[DEPTH-1:1]};
      end
      if (cnt_q == CNT_W'(DEPTH - 1)) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stage_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign o_ser_out    = i_dir ? stage_q[0] : stage_q[DEPTH-1];
  assign o_par_out    = stage_q;
  assign o_cnt        = cnt_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ.
// Instance a is 1-bit x 8 stages, instance b is 4-bit x 4 stages.
module tb_shift_reg_univ;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic       a_rst, a_en, a_load, a_dir, a_rot;
  logic [0:0] a_sin, a_sout;
  logic [7:0] a_pin, a_pout;
  logic [2:0] a_cnt;
  logic       a_done;

  logic        b_rst, b_en, b_load, b_dir, b_rot;
  logic [3:0]  b_sin, b_sout;
  logic [15:0] b_pin, b_pout;
  logic [1:0]  b_cnt;
  logic        b_done;

  shift_reg_univ #(.DATA_W(1), .DEPTH(8)) u_a (
    .i_clk(clk), .i_rst(a_rst), .i_en(a_en), .i_load(a_load),
    .i_dir(a_dir),
`ifdef SHIFT_REG_ROT_EN
    .i_rot(a_rot),
`endif
    .i_ser_in(a_sin), .i_par_in(a_pin), .o_ser_out(a_sout),
    .o_par_out(a_pout), .o_cnt(a_cnt), .o_frame_done(a_done)
  );

  shift_reg_univ #(.DATA_W(4), .DEPTH(4)) u_b (
    .i_clk(clk), .i_rst(b_rst), .i_en(b_en), .i_load(b_load),
    .i_dir(b_dir),
`ifdef SHIFT_REG_ROT_EN
    .i_rot(b_rot),
`endif
    .i_ser_in(b_sin), .i_par_in(b_pin), .o_ser_out(b_sout),
    .o_par_out(b_pout), .o_cnt(b_cnt), .o_frame_done(b_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_load_val(input logic [7:0] v);
    a_load = 1'b1; a_pin = v;
    tick();
    a_load = 1'b0;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    tick(); tick();
    a_rst = 1'b0; b_rst = 1'b0;
    n_vec++;
    if (a_pout !== 8'h00 || a_cnt !== 3'd0 || a_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_a: par=%h cnt=%0d done=%b want 00/0/0",
               a_pout, a_cnt, a_done);
    end
    n_vec++;
    if (b_pout !== 16'h0 || b_cnt !== 2'd0 || b_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_b: par=%h cnt=%0d done=%b want 0000/0/0",
               b_pout, b_cnt, b_done);
    end
    for (int d = 0; d < 2; d++) begin
      a_dir = d[0]; #1;
      n_vec++;
      if (a_sout !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_ser dir=%0d: got %b want 0", d, a_sout);
      end
    end
    a_dir = 1'b0;
  endtask

  task automatic test_shift_up();
    logic [7:0] exp_ser;
    exp_ser = 8'b0010_1101;
    a_load_val(8'h2D);
    a_dir = 1'b0; a_sin = 1'b0; a_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_vec++;
      if (a_sout !== exp_ser[7-i] || a_done !== 1'b0) begin
        n_bad++;
        $display("FAIL up_ser[%0d]: ser=%b done=%b want %b/0",
                 i, a_sout, a_done, exp_ser[7-i]);
      end
      tick();
      n_vec++;
      if (a_cnt !== 3'((i + 1) % 8)) begin
        n_bad++;
        $display("FAIL up_cnt[%0d]: got %0d want %0d", i, a_cnt, (i + 1) % 8);
      end
    end
    a_en = 1'b0;
    n_vec++;
    if (a_pout !== 8'h00 || a_done !== 1'b1) begin
      n_bad++;
      $display("FAIL up_end: par=%h done=%b want 00/1", a_pout, a_done);
    end
    tick();
    n_vec++;
    if (a_done !== 1'b0) begin
      n_bad++;
      $display("FAIL up_pulse_width: done=%b want 0", a_done);
    end
  endtask

  task automatic test_shift_down();
    logic [7:0] exp_ser;
    exp_ser = 8'b0010_1101;
    a_load_val(8'h2D);
    a_dir = 1'b1; a_sin = 1'b1; a_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_vec++;
      if (a_sout !== exp_ser[i]) begin
        n_bad++;
        $display("FAIL dn_ser[%0d]: got %b want %b", i, a_sout, exp_ser[i]);
      end
      tick();
    end
    a_en = 1'b0;
    n_vec++;
    if (a_pout !== 8'hFF || a_cnt !== 3'd0 || a_done !== 1'b1) begin
      n_bad++;
      $display("FAIL dn_end: par=%h cnt=%0d done=%b want FF/0/1",
               a_pout, a_cnt, a_done);
    end
    tick();
    a_dir = 1'b0; a_sin = 1'b0;
  endtask

  task automatic test_lanes();
    b_load = 1'b1; b_pin = 16'h1234; b_dir = 1'b0;
    tick();
    b_load = 1'b0;
    n_vec++;
    if (b_sout !== 4'h1) begin
      n_bad++;
      $display("FAIL lane_up_pre: got %h want 1", b_sout);
    end
    b_en = 1'b1; b_sin = 4'hF;
    tick();
    b_en = 1'b0;
    n_vec++;
    if (b_pout !== 16'h234F || b_sout !== 4'h2 || b_cnt !== 2'd1) begin
      n_bad++;
      $display("FAIL lane_up: par=%h ser=%h cnt=%0d want 234F/2/1",
               b_pout, b_sout, b_cnt);
    end
    b_load = 1'b1; b_pin = 16'h1234; b_dir = 1'b1;
    tick();
    b_load = 1'b0;
    n_vec++;
    if (b_sout !== 4'h4 || b_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL lane_dn_pre: ser=%h cnt=%0d want 4/0", b_sout, b_cnt);
    end
    b_en = 1'b1; b_sin = 4'hE;
    tick();
    b_en = 1'b0;
    n_vec++;
    if (b_pout !== 16'hE123 || b_sout !== 4'h3) begin
      n_bad++;
      $display("FAIL lane_dn: par=%h ser=%h want E123/3", b_pout, b_sout);
    end
  endtask

  task automatic test_priority_hold();
    a_dir = 1'b0; a_sin = 1'b0; a_en = 1'b1;
    tick(); tick();
    a_load = 1'b1; a_pin = 8'h2D;
    tick();
    a_load = 1'b0;
    n_vec++;
    if (a_pout !== 8'h2D || a_cnt !== 3'd0) begin
      n_bad++;
      $display("FAIL load_wins: par=%h cnt=%0d want 2D/0", a_pout, a_cnt);
    end
    tick(); tick(); tick();
    a_en = 1'b0;
    n_vec++;
    if (a_pout !== 8'h68 || a_cnt !== 3'd3) begin
      n_bad++;
      $display("FAIL three_shifts: par=%h cnt=%0d want 68/3", a_pout, a_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (a_pout !== 8'h68 || a_cnt !== 3'd3 || a_done !== 1'b0) begin
        n_bad++;
        $display("FAIL hold[%0d]: par=%h cnt=%0d done=%b want 68/3/0",
                 i, a_pout, a_cnt, a_done);
      end
    end
  endtask

  task automatic test_reset_mid();
    a_load_val(8'hA5);
    a_dir = 1'b0; a_sin = 1'b1; a_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    n_vec++;
    if (a_pout !== 8'h00 || a_cnt !== 3'd0 || a_done !== 1'b0 ||
        a_sout !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid: par=%h cnt=%0d done=%b ser=%b want 00/0/0/0",
               a_pout, a_cnt, a_done, a_sout);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (a_done !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_no_pulse[%0d]: done=%b want 0", i, a_done);
      end
    end
    a_en = 1'b0; a_sin = 1'b0;
  endtask

`ifdef SHIFT_REG_ROT_EN
  task automatic test_rotate();
    int pulses;
    pulses = 0;
    a_load_val(8'h2D);
    a_rot = 1'b1; a_dir = 1'b0; a_sin = 1'b1; a_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (a_done === 1'b1) pulses++;
      if (i == 0) begin
        n_vec++;
        if (a_pout !== 8'h5A) begin
          n_bad++;
          $display("FAIL rot_first: got %h want 5A", a_pout);
        end
      end
    end
    a_en = 1'b0;
    n_vec++;
    if (a_pout !== 8'h2D || pulses != 1) begin
      n_bad++;
      $display("FAIL rot_end: par=%h pulses=%0d want 2D/1", a_pout, pulses);
    end
    tick();
    a_rot = 1'b0; a_sin = 1'b0;
  endtask
`endif

  initial begin
    a_rst = 1'b0; a_en = 1'b0; a_load = 1'b0; a_dir = 1'b0; a_rot = 1'b0;
    a_sin = '0; a_pin = '0;
    b_rst = 1'b0; b_en = 1'b0; b_load = 1'b0; b_dir = 1'b0; b_rot = 1'b0;
    b_sin = '0; b_pin = '0;
    test_reset();
    test_shift_up();
    test_shift_down();
    test_lanes();
    test_priority_hold();
    test_reset_mid();
`ifdef SHIFT_REG_ROT_EN
    test_rotate();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
- Parametrised universal shift register; next generation of the single-bit serial-in/serial-out delay line.
- Adds multi-bit lanes, parallel load, parallel readout and bidirectional shift.
- Adds a shift counter that pulses a frame-done flag after every DEPTH shifts.
- Used for serialisers/deserialisers and configurable delay lines in the FIFO datapath and test logic.

Parameters:
- DATA_W, 1, bits per stage (lane width); must be >= 1.
- DEPTH, 8, number of stages; must be >= 2.
- CNT_W, $clog2(DEPTH), localparam, width of the shift counter.

Ports:
- i_clk  in  1  clock; all state changes on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  shift enable.
- i_load  in  1  parallel load strobe.
- i_dir  in  1  0 = shift toward MSB stage; 1 = shift toward stage 0.
- i_ser_in  in  DATA_W  serial lane input.
- i_par_in  in  DEPTH*DATA_W  parallel load data. Stage k = bits [k*DATA_W +: DATA_W]; stage DEPTH-1 is the MSB.
- o_ser_out  out  DATA_W  serial output. Combinational: stage DEPTH-1 when i_dir=0, stage 0 when i_dir=1.
- o_par_out  out  DEPTH*DATA_W  all stages; registered.
- o_cnt  out  CNT_W  shifts since last load/reset, modulo DEPTH; registered.
- o_frame_done  out  1  one-cycle registered pulse.

Behaviour:
- Reset behaviour (i_rst=1 at an edge):
  - All stages, o_cnt and o_frame_done are set to 0.
  - o_par_out therefore reads 0, and o_ser_out reads 0.
  - Reset mid-frame discards the frame; no frame-done pulse is produced.
- Priority at each edge: i_rst > i_load > i_en > hold.
- Load:
  - stages <= i_par_in; o_cnt <= 0; o_frame_done <= 0.
  - i_en is ignored in the same cycle.
- Shift, i_dir=0:
  - stage[k] <= stage[k-1] for k = DEPTH-1..1.
  - stage[0] <= i_ser_in.
- Shift, i_dir=1:
  - stage[k] <= stage[k+1] for k = 0..DEPTH-2.
  - stage[DEPTH-1] <= i_ser_in.
- Counter on a shift:
  - If o_cnt == DEPTH-1: o_cnt <= 0 and o_frame_done <= 1.
  - Otherwise: o_cnt <= o_cnt+1 and o_frame_done <= 0.
- Hold (i_en=0, no load, no reset): stages and o_cnt keep their values; o_frame_done <= 0.
- Timing:
  - o_frame_done is high for exactly the one cycle after the DEPTH-th shift edge.
  - No pulse when shifting stalls.
- i_dir may change between any two shifts. The counter is direction-agnostic.
- o_ser_out follows i_dir combinationally with zero latency.
- Latency: a serial input appears at the far end after DEPTH enabled shifts.

Optional Feature:
- Macro: SHIFT_REG_ROT_EN.
- When defined:
  - Adds input port i_rot (1 bit).
  - While i_rot=1, a shift feeds the outgoing end stage back in place of i_ser_in (rotate).
  - i_dir=0: stage[0] <= old stage[DEPTH-1].
  - i_dir=1: stage[DEPTH-1] <= old stage[0].
  - Counter and frame-done behave as for a normal shift.
- When undefined:
  - Port i_rot does not exist.
  - The shift always takes i_ser_in.

Test Plan:
- DATA_W=1, DEPTH=8:
  - Stimulus: load 8'h2D; i_dir=0; i_ser_in=0; 8 consecutive shifts.
  - Required: o_ser_out before each edge = 0,0,1,0,1,1,0,1.
  - Required: after the 8th edge, o_par_out=8'h00 and o_cnt=0; o_frame_done is high for 1 cycle.
- Same configuration, i_dir=1:
  - Stimulus: load 8'h2D, then shift.
  - Required: o_ser_out sequence = 1,0,1,1,0,1,0,0.
  - Required: with i_ser_in=1 throughout, o_par_out ends at 8'hFF.
- DATA_W=4, DEPTH=4:
  - Stimulus: load 16'h1234, then one shift with i_dir=0 and i_ser_in=4'hF.
  - Required: o_par_out=16'h234F; o_ser_out read 4'h1 before the edge and 4'h2 after.
  - Stimulus: reload 16'h1234, then one shift with i_dir=1 and i_ser_in=4'hE.
  - Required: o_par_out=16'hE123; o_ser_out read 4'h4 before the edge and 4'h3 after.
- Priority and hold:
  - i_load=1 with i_en=1 → the load wins and o_cnt=0.
  - 3 shifts, then i_en=0 for 5 cycles → o_par_out and o_cnt=3 are unchanged; no o_frame_done.
  - i_rst=1 after 5 of 8 shifts → all outputs are 0 the next cycle; o_frame_done never pulses.
- SHIFT_REG_ROT_EN defined, DEPTH=8:
  - Stimulus: load 8'h2D; i_rot=1; i_dir=0; 8 shifts.
  - Required: o_par_out returns to 8'h2D, and o_frame_done pulses once.
  - Required: after the 1st edge, o_par_out=8'h5A.
